// File: rtl/sakebi_rmii_rx_axis.sv
// RMII receive front end: preamble/SFD detection, LSB-first dibit assembly into
// AXI-Stream beats with TKEEP/TLAST/TUSER, and a small FWFT beat FIFO.
// Ports:
//   i_rmii_REF_CLK        sole clock (RMII reference)
//   i_rmii_RESET          synchronous active-high reset
//   i_rmii_CRS_DV/RXD/RX_ER  RMII receive inputs (registered once on entry)
//   i_speed_100           1 = 100 Mb/s, 0 = 10 Mb/s (latched while idle)
//   o_axis_*/i_axis_TREADY   AXI-Stream master; TUSER flags a bad frame on TLAST
//   o_overflow            one-cycle pulse when a beat is dropped on a full FIFO
module sakebi_rmii_rx_axis #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    i_rmii_REF_CLK,
    input  logic                    i_rmii_RESET,
    input  logic                    i_rmii_CRS_DV,
    input  logic [1:0]              i_rmii_RXD,
    input  logic                    i_rmii_RX_ER,
    input  logic                    i_speed_100,
    output logic                    o_axis_TVALID,
    input  logic                    i_axis_TREADY,
    output logic [DATA_WIDTH-1:0]   o_axis_TDATA,
    output logic [DATA_WIDTH/8-1:0] o_axis_TKEEP,
    output logic                    o_axis_TLAST,
    output logic                    o_axis_TUSER,
    output logic                    o_overflow
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned BCW   = 11;

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [BYTES-1:0]      keep;
        logic                  last;
        logic                  user;
    } beat_t;

    state_t           state, next_state;
    logic             crs_q, rx_er_q;
    logic [1:0]       rxd_q;
    logic             spd;
    logic [3:0]       div;
    logic             pend_valid;
    logic [1:0]       pend_d;
    logic             low_seen;
    logic [7:0]       sb;
    logic [1:0]       dcnt;
    logic [BCW-1:0]   bcnt;
    logic [LW-1:0]    lane;
    logic [DATA_WIDTH-1:0] beat;
    logic [BYTES-1:0] keep;
    logic             err;
    logic             term_pend;
    logic             overflow;
    beat_t            mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;

    logic             strobe_c, sfd_c, take_c, hold_c, end_c;
    logic [1:0]       first_d_c, dc1_c, dc2_c, dc_nx_c;
    logic [7:0]       sb1_c, sb2_c, sb_nx_c, byte_val_c;
    logic             byte_done_c, keep_full_c;
    logic             push_data_c, push_end_c, push_term_c;
    logic             pop_c, full_c, empty_c, space_c, wr_en_c, ovf_c;
    logic [AW:0]      count_c;
    logic [LW-1:0]    lane_inc_c;
    beat_t            wr_entry_c, head_c;

    // Input stage: every decision below uses these registered copies
    always_ff @(posedge i_rmii_REF_CLK) begin
        if (i_rmii_RESET) begin
            crs_q   <= 1'b0;
            rxd_q   <= 2'b00;
            rx_er_q <= 1'b0;
        end else begin
            crs_q   <= i_rmii_CRS_DV;
            rxd_q   <= i_rmii_RXD;
            rx_er_q <= i_rmii_RX_ER;
        end
    end

    assign strobe_c = spd || (div == 4'd0);

    // State register
    always_ff @(posedge i_rmii_REF_CLK) begin
        if (i_rmii_RESET) state <= IDLE;
        else              state <= next_state;
    end

    // Next-state logic; an overflow always diverts the frame to DROP
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (crs_q && !term_pend) next_state = PREAMBLE;
            PREAMBLE: if (strobe_c) begin
                          if (!crs_q)               next_state = IDLE;
                          else if (rxd_q == 2'b11)  next_state = DATA;
                          else if (rxd_q == 2'b10)  next_state = DROP;
                      end
            DATA:     if (strobe_c && !crs_q && pend_valid) next_state = IDLE;
            DROP:     if (strobe_c && !crs_q && low_seen)   next_state = IDLE;
            default:  next_state = IDLE;
        endcase
        if (ovf_c) next_state = DROP;
    end

    // Per-state control decode
    always_comb begin
        sfd_c  = 1'b0;
        take_c = 1'b0;
        hold_c = 1'b0;
        end_c  = 1'b0;
        case (state)
            PREAMBLE: sfd_c = strobe_c && crs_q && (rxd_q == 2'b11);
            DATA: begin
                take_c = strobe_c && crs_q;
                hold_c = strobe_c && !crs_q && !pend_valid;
                end_c  = strobe_c && !crs_q && pend_valid;
            end
            default: ;
        endcase
    end

    // Dibit shifter: up to two dibits (pending + current) per strobe,
    // which can complete at most one byte
    always_comb begin
        first_d_c   = pend_valid ? pend_d : rxd_q;
        sb1_c       = {first_d_c, sb[7:2]};
        dc1_c       = dcnt + 2'd1;
        sb2_c       = {rxd_q, sb1_c[7:2]};
        dc2_c       = dc1_c + 2'd1;
        sb_nx_c     = pend_valid ? sb2_c : sb1_c;
        dc_nx_c     = pend_valid ? dc2_c : dc1_c;
        byte_done_c = take_c && ((dc1_c == 2'd0) || (pend_valid && (dc2_c == 2'd0)));
        byte_val_c  = (dc1_c == 2'd0) ? sb1_c : sb2_c;
    end

    assign keep_full_c = &keep;
    assign lane_inc_c  = (lane == LW'(BYTES - 1)) ? '0 : lane + LW'(1);

    // FIFO push/pop arbitration; a full beat is only pushed once the next byte arrives
    always_comb begin
        count_c     = wr_ptr - rd_ptr;
        empty_c     = (wr_ptr == rd_ptr);
        full_c      = (count_c == (AW + 1)'(FIFO_DEPTH));
        pop_c       = !empty_c && i_axis_TREADY;
        space_c     = !full_c || pop_c;
        push_data_c = byte_done_c && keep_full_c;
        push_end_c  = end_c && (bcnt != '0);
        push_term_c = term_pend;
        ovf_c       = (push_data_c || push_end_c) && !space_c;
        wr_en_c     = (push_data_c || push_end_c || push_term_c) && space_c;
        wr_entry_c  = '0;
        if (push_end_c) begin
            wr_entry_c.data = beat;
            wr_entry_c.keep = keep;
            wr_entry_c.last = 1'b1;
            wr_entry_c.user = err || rx_er_q || (dcnt != 2'd0);
        end else if (push_data_c) begin
            wr_entry_c.data = beat;
            wr_entry_c.keep = keep;
        end else begin
            wr_entry_c.last = 1'b1;
            wr_entry_c.user = 1'b1;
        end
    end

    // Frame datapath: divider, pending dibit, byte/beat assembly, flags
    always_ff @(posedge i_rmii_REF_CLK) begin
        if (i_rmii_RESET) begin
            spd        <= 1'b0;
            div        <= 4'd0;
            pend_valid <= 1'b0;
            pend_d     <= 2'b00;
            low_seen   <= 1'b0;
            sb         <= 8'h00;
            dcnt       <= 2'd0;
            bcnt       <= '0;
            lane       <= '0;
            beat       <= '0;
            keep       <= '0;
            err        <= 1'b0;
            term_pend  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            overflow <= ovf_c;
            if (state == IDLE) begin
                spd <= i_speed_100;
                div <= 4'd0;
            end else begin
                div <= (div == 4'd9) ? 4'd0 : div + 4'd1;
            end

            if (state != DATA) begin
                pend_valid <= 1'b0;
            end else if (hold_c) begin
                pend_valid <= 1'b1;
                pend_d     <= rxd_q;
            end else if (take_c || end_c) begin
                pend_valid <= 1'b0;
            end

            if (state != DROP)  low_seen <= 1'b0;
            else if (strobe_c)  low_seen <= !crs_q;

            if (sfd_c) begin
                sb   <= 8'h00;
                dcnt <= 2'd0;
                bcnt <= '0;
                lane <= '0;
                beat <= '0;
                keep <= '0;
                err  <= 1'b0;
            end
            if ((state == DATA) && strobe_c && rx_er_q) err <= 1'b1;
            if (take_c) begin
                sb   <= sb_nx_c;
                dcnt <= dc_nx_c;
            end
            if (byte_done_c) begin
                if (bcnt != {BCW{1'b1}}) bcnt <= bcnt + BCW'(1);
                lane <= lane_inc_c;
                // A full beat is being pushed this cycle; restart in lane 0
                for (int unsigned i = 0; i < BYTES; i++) begin
                    if (keep_full_c) begin
                        beat[8*i +: 8] <= (i == 0) ? byte_val_c : 8'h00;
                        keep[i]        <= (i == 0);
                    end else if (lane == LW'(i)) begin
                        beat[8*i +: 8] <= byte_val_c;
                        keep[i]        <= 1'b1;
                    end
                end
            end

            if (ovf_c)                           term_pend <= 1'b1;
            else if (push_term_c && space_c)     term_pend <= 1'b0;
        end
    end

    // FIFO pointers
    always_ff @(posedge i_rmii_REF_CLK) begin
        if (i_rmii_RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en_c) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (pop_c)   rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    // FIFO storage
    always_ff @(posedge i_rmii_REF_CLK) begin
        if (wr_en_c) mem[wr_ptr[AW-1:0]] <= wr_entry_c;
    end

    // FWFT head; forced to zero while empty so reset shows all-zero outputs
    assign head_c        = empty_c ? '0 : mem[rd_ptr[AW-1:0]];
    assign o_axis_TVALID = !empty_c;
    assign o_axis_TDATA  = head_c.data;
    assign o_axis_TKEEP  = head_c.keep;
    assign o_axis_TLAST  = head_c.last;
    assign o_axis_TUSER  = head_c.user;
    assign o_overflow    = overflow;

endmodule

// File: tb/tb_sakebi_rmii_rx_axis.sv
// Bench for sakebi_rmii_rx_axis: two instances (16-bit and 8-bit beats) share
// the RMII stimulus; expected beats are queued per instance and checked on handshake.
module tb_sakebi_rmii_rx_axis;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, crs, er, spd, rdy;
    logic [1:0] rxd;

    logic        v16, l16, u16, o16;
    logic [15:0] d16;
    logic [1:0]  k16;
    logic        v8, l8, u8, o8;
    logic [7:0]  d8;
    logic [0:0]  k8;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   ovf16 = 0;
    int   ovf8 = 0;
    int   prev8 = -1;
    bit   t2_on = 1'b0;
    exp_t q16[$];
    exp_t q8[$];
    exp_t e16, e8;
    logic [3:0] stim[$];
    logic [7:0] fb[$];

    always #5 clk = ~clk;

    sakebi_rmii_rx_axis #(.DATA_WIDTH(16), .FIFO_DEPTH(4)) u_dut16 (
        .i_rmii_REF_CLK(clk), .i_rmii_RESET(rst), .i_rmii_CRS_DV(crs),
        .i_rmii_RXD(rxd), .i_rmii_RX_ER(er), .i_speed_100(spd),
        .o_axis_TVALID(v16), .i_axis_TREADY(rdy), .o_axis_TDATA(d16),
        .o_axis_TKEEP(k16), .o_axis_TLAST(l16), .o_axis_TUSER(u16),
        .o_overflow(o16)
    );

    sakebi_rmii_rx_axis #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) u_dut8 (
        .i_rmii_REF_CLK(clk), .i_rmii_RESET(rst), .i_rmii_CRS_DV(crs),
        .i_rmii_RXD(rxd), .i_rmii_RX_ER(er), .i_speed_100(spd),
        .o_axis_TVALID(v8), .i_axis_TREADY(rdy), .o_axis_TDATA(d8),
        .o_axis_TKEEP(k8), .o_axis_TLAST(l8), .o_axis_TUSER(u8),
        .o_overflow(o8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Stimulus builders: entries are {rx_er, crs_dv, rxd}
    task automatic add_byte(input logic [7:0] b, input bit tog, input bit er_pulse);
        for (int k = 0; k < 4; k++) begin
            logic c, e;
            c = tog ? logic'(k % 2 == 1) : 1'b1;
            e = er_pulse && (k == 1);
            stim.push_back({e, c, b[2*k +: 2]});
        end
    endtask

    task automatic frame_byte(input logic [7:0] b, input bit tog, input bit er_pulse);
        add_byte(b, tog, er_pulse);
        fb.push_back(b);
    endtask

    task automatic add_pre();
        for (int i = 0; i < 7; i++) add_byte(8'h55, 1'b0, 1'b0);
        add_byte(8'hD5, 1'b0, 1'b0);
        fb.delete();
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) stim.push_back(4'b0000);
    endtask

    task automatic push_exp(input bit sel, input exp_t e);
        if (sel) q16.push_back(e);
        else     q8.push_back(e);
    endtask

    // Reference chunking of the frame bytes into beats of nb bytes
    task automatic exp_beats(input int nb, input bit sel, input bit user);
        exp_t e;
        int   n;
        n = fb.size();
        for (int i = 0; i < n; i += nb) begin
            e = '0;
            for (int j = 0; j < nb && i + j < n; j++) begin
                e.data[8*j +: 8] = fb[i+j];
                e.keep[j]        = 1'b1;
            end
            e.last = (i + nb >= n);
            e.user = e.last && user;
            push_exp(sel, e);
        end
    endtask

    task automatic exp_frame(input bit user);
        exp_beats(2, 1'b1, user);
        exp_beats(1, 1'b0, user);
        fb.delete();
    endtask

    // Four full beats fit the FIFO, then the terminator
    task automatic exp_trunc(input int nb, input bit sel);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e = '0;
            for (int j = 0; j < nb; j++) begin
                e.data[8*j +: 8] = fb[i*nb + j];
                e.keep[j]        = 1'b1;
            end
            push_exp(sel, e);
        end
        e = '0;
        e.last = 1'b1;
        e.user = 1'b1;
        push_exp(sel, e);
    endtask

    task automatic play(input int hold);
        foreach (stim[i]) begin
            {er, crs, rxd} = stim[i];
            repeat (hold) begin
                @(posedge clk);
                #1;
            end
        end
        stim.delete();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q16.size() != 0 || q8.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_dut16", 64'(q16.size()), 64'd0);
        chk("drain_dut8", 64'(q8.size()), 64'd0);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (o16) ovf16++;
        if (o8)  ovf8++;
    end

    always @(negedge clk) begin
        if (v16 && rdy) begin
            if (q16.size() == 0) begin
                chk("dut16_extra_beat", 64'(v16), 64'd0);
            end else begin
                e16 = q16.pop_front();
                chk("dut16_tdata", 64'(d16 & {{8{e16.keep[1]}}, {8{e16.keep[0]}}}), e16.data);
                chk("dut16_tkeep", 64'(k16), 64'(e16.keep));
                chk("dut16_tlast", 64'(l16), 64'(e16.last));
                chk("dut16_tuser", 64'(u16), 64'(e16.user));
            end
        end
    end

    always @(negedge clk) begin
        if (v8 && rdy) begin
            if (q8.size() == 0) begin
                chk("dut8_extra_beat", 64'(v8), 64'd0);
            end else begin
                e8 = q8.pop_front();
                chk("dut8_tdata", 64'(d8 & {8{e8.keep[0]}}), e8.data);
                chk("dut8_tkeep", 64'(k8), 64'(e8.keep));
                chk("dut8_tlast", 64'(l8), 64'(e8.last));
                chk("dut8_tuser", 64'(u8), 64'(e8.user));
                if (t2_on && !l8 && prev8 >= 0)
                    chk("t2_spacing_ge40", 64'(cyc - prev8 >= 40), 64'd1);
                if (t2_on) prev8 = cyc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; crs = 1'b0; er = 1'b0; rxd = 2'b00; spd = 1'b1; rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid16", 64'(v16), 64'd0);
        chk("rst_tdata16", 64'(d16), 64'd0);
        chk("rst_tkeep16", 64'(k16), 64'd0);
        chk("rst_tlast16", 64'(l16), 64'd0);
        chk("rst_tuser16", 64'(u16), 64'd0);
        chk("rst_ovf16", 64'(o16), 64'd0);
        chk("rst_tvalid8", 64'(v8), 64'd0);
        chk("rst_tdata8", 64'(d8), 64'd0);
        chk("rst_tkeep8", 64'(k8), 64'd0);
        chk("rst_tlast8", 64'(l8), 64'd0);
        chk("rst_tuser8", 64'(u8), 64'd0);
        chk("rst_ovf8", 64'(o8), 64'd0);
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // 100M basic frame
        add_pre();
        frame_byte(8'h01, 1'b0, 1'b0);
        frame_byte(8'h02, 1'b0, 1'b0);
        frame_byte(8'h03, 1'b0, 1'b0);
        exp_frame(1'b0);
        add_idle(6);
        play(1);
        drain();

        // 10M: each dibit held 10 cycles
        spd = 1'b0;
        t2_on = 1'b1;
        add_pre();
        frame_byte(8'h01, 1'b0, 1'b0);
        frame_byte(8'h02, 1'b0, 1'b0);
        frame_byte(8'h03, 1'b0, 1'b0);
        exp_frame(1'b0);
        add_idle(6);
        play(10);
        drain();
        t2_on = 1'b0;
        spd = 1'b1;
        repeat (4) begin @(posedge clk); #1; end

        // CRS_DV toggling across the last two bytes
        add_pre();
        frame_byte(8'h10, 1'b0, 1'b0);
        frame_byte(8'hAA, 1'b1, 1'b0);
        frame_byte(8'hBB, 1'b1, 1'b0);
        exp_frame(1'b0);
        add_idle(6);
        play(1);
        drain();

        // Alignment error, then RX_ER inside a byte
        add_pre();
        frame_byte(8'h11, 1'b0, 1'b0);
        frame_byte(8'h22, 1'b0, 1'b0);
        stim.push_back(4'b0101);
        exp_frame(1'b1);
        add_idle(6);
        add_pre();
        frame_byte(8'h33, 1'b0, 1'b0);
        frame_byte(8'h44, 1'b0, 1'b1);
        exp_frame(1'b1);
        add_idle(6);
        play(1);
        drain();

        // Overflow with TREADY held low
        ovf16 = 0;
        ovf8 = 0;
        rdy = 1'b0;
        add_pre();
        for (int i = 1; i <= 10; i++) frame_byte(8'(i), 1'b0, 1'b0);
        exp_trunc(2, 1'b1);
        exp_trunc(1, 1'b0);
        fb.delete();
        add_idle(8);
        play(1);
        repeat (4) begin @(posedge clk); #1; end
        rdy = 1'b1;
        drain();
        chk("ovf_pulses16", 64'(ovf16), 64'd1);
        chk("ovf_pulses8", 64'(ovf8), 64'd1);

        // Bad preamble dibit: nothing delivered
        for (int i = 0; i < 4; i++) stim.push_back(4'b0101);
        stim.push_back(4'b0110);
        add_byte(8'h12, 1'b0, 1'b0);
        add_byte(8'h34, 1'b0, 1'b0);
        add_idle(8);
        play(1);
        repeat (10) begin @(posedge clk); #1; end
        chk("badpre_tvalid16", 64'(v16), 64'd0);
        chk("badpre_tvalid8", 64'(v8), 64'd0);

        // Reset mid-frame with beats queued
        rdy = 1'b0;
        add_pre();
        add_byte(8'hAA, 1'b0, 1'b0);
        add_byte(8'hBB, 1'b0, 1'b0);
        add_byte(8'hCC, 1'b0, 1'b0);
        add_byte(8'hDD, 1'b0, 1'b0);
        play(1);
        chk("prerst_tvalid16", 64'(v16), 64'd1);
        chk("prerst_tvalid8", 64'(v8), 64'd1);
        rst = 1'b1; crs = 1'b0; rxd = 2'b00; er = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_tvalid16", 64'(v16), 64'd0);
        chk("midrst_tvalid8", 64'(v8), 64'd0);
        rst = 1'b0;
        rdy = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        add_pre();
        frame_byte(8'h5A, 1'b0, 1'b0);
        frame_byte(8'hA5, 1'b0, 1'b0);
        frame_byte(8'h3C, 1'b0, 1'b0);
        exp_frame(1'b0);
        add_idle(6);
        play(1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
